// File: rtl/rx_pkg.sv
// Shared definitions for the CDL receive path: data-ready FSM state type,
// default FIFO occupancy/count widths and the FIFO depth helper.
package rx_pkg;

    // Data-ready controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        ERROR = 2'd2
    } rx_rdy_state_t;

    // Default widths shared with the RX FIFO
    localparam int RX_OCC_W = 7;
    localparam int RX_CNT_W = 3;

    // FIFO depth implied by an occupancy width (one extra bit encodes "full")
    function automatic int occ_depth(input int occ_w);
        return 32'sd1 << (occ_w - 32'sd1);
    endfunction

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating up-counter with synchronous clear; used wherever a CDL block
// needs an event count that must never wrap back to zero.
module rx_sat_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic at_max_s;

    // Saturation detect
    always_comb begin
        at_max_s = (count == CNT_MAX);
    end

    // Count register: clear wins over increment, increment stops at the maximum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (clr) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && !at_max_s) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/rx_data_ready_ctrl.sv
// Receive-side data-ready controller for the CDL receiver.
// Tracks completed packets held in the RX FIFO, raises rx_data_ready to the
// host until the FIFO drains, reports aborted packets as a sticky error that
// only a flush clears, and flags when the FIFO is close to capacity.
// Optional build macro RX_EARLY_READY_EN: when defined, an occupancy at or
// above EARLY_THRESH in IDLE also raises rx_data_ready before pkt_done.
module rx_data_ready_ctrl
    import rx_pkg::*;
#(
    parameter int OCC_W        = RX_OCC_W,
    parameter int CNT_W        = RX_CNT_W,
    parameter int AF_MARGIN    = 4,
    parameter int EARLY_THRESH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_done,
    input  logic             pkt_err,
    input  logic             flush,
    input  logic [OCC_W-1:0] buffer_occupancy,
    output logic             rx_data_ready,
    output logic             rx_error,
    output logic [CNT_W-1:0] pkt_count,
    output logic             almost_full
);

    localparam int               DEPTH    = occ_depth(OCC_W);
    localparam logic [OCC_W-1:0] AF_LEVEL = OCC_W'(DEPTH - AF_MARGIN);

    rx_rdy_state_t state_r;
    rx_rdy_state_t nxt_state_s;
    logic          ready_r;
    logic          error_r;
    logic          af_r;
    logic          occ_empty_s;
    logic          af_hit_s;
    logic          early_s;
    logic          cnt_inc_s;
    logic          cnt_clr_s;

`ifdef RX_EARLY_READY_EN
    localparam logic [OCC_W-1:0] EARLY_LEVEL = OCC_W'(EARLY_THRESH);

    // Early-ready detect: enough data buffered to start draining before pkt_done
    always_comb begin
        early_s = (buffer_occupancy >= EARLY_LEVEL);
    end
`else
    // Early ready not built: only pkt_done can enter READY
    always_comb begin
        early_s = 1'b0;
    end

    // The threshold has no meaning in this build; keep it referenced only here
    if (EARLY_THRESH < 0) begin : g_early_thresh_unused
    end
`endif

    // Occupancy compares, unsigned at OCC_W bits (values above DEPTH read as full)
    always_comb begin
        occ_empty_s = (buffer_occupancy == {OCC_W{1'b0}});
        af_hit_s    = (buffer_occupancy >= AF_LEVEL);
    end

    // Next-state decode: flush beats pkt_err, pkt_err beats pkt_done
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    nxt_state_s = IDLE;
                end else if (pkt_err) begin
                    nxt_state_s = ERROR;
                end else if (pkt_done || early_s) begin
                    nxt_state_s = READY;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            READY: begin
                if (flush) begin
                    nxt_state_s = IDLE;
                end else if (pkt_err) begin
                    nxt_state_s = ERROR;
                end else if (occ_empty_s && !pkt_done) begin
                    nxt_state_s = IDLE;
                end else begin
                    nxt_state_s = READY;
                end
            end
            ERROR: begin
                if (flush) begin
                    nxt_state_s = IDLE;
                end else begin
                    nxt_state_s = ERROR;
                end
            end
            default: begin
                nxt_state_s = IDLE;
            end
        endcase
    end

    // Packet-count control: count completed packets, clear whenever READY is left
    always_comb begin
        cnt_inc_s = 1'b0;
        cnt_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_clr_s = flush || pkt_err;
                cnt_inc_s = pkt_done && !flush && !pkt_err;
            end
            READY: begin
                cnt_clr_s = flush || pkt_err || (occ_empty_s && !pkt_done);
                cnt_inc_s = pkt_done && !flush && !pkt_err;
            end
            ERROR: begin
                // Count is already zero here; holding the clear keeps it there
                cnt_clr_s = 1'b1;
                cnt_inc_s = 1'b0;
            end
            default: begin
                cnt_clr_s = 1'b1;
                cnt_inc_s = 1'b0;
            end
        endcase
    end

    // FSM state and its registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            ready_r <= (nxt_state_s == READY);
            error_r <= (nxt_state_s == ERROR);
        end
    end

    // Almost-full flag follows occupancy in every state; only reset forces it low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            af_r <= 1'b0;
        end else begin
            af_r <= af_hit_s;
        end
    end

    rx_sat_counter #(
        .CNT_W (CNT_W)
    ) u_pkt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc_s),
        .clr   (cnt_clr_s),
        .count (pkt_count)
    );

    // Drive the ports from their registers
    always_comb begin
        rx_data_ready = ready_r;
        rx_error      = error_r;
        almost_full   = af_r;
    end

endmodule

// File: tb/tb_rx_data_ready_ctrl.sv
// Self-checking bench for rx_data_ready_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of the controller's rules.
module tb_rx_data_ready_ctrl;

    localparam int OCC_W        = 7;
    localparam int CNT_W        = 3;
    localparam int AF_MARGIN    = 4;
    localparam int EARLY_THRESH = 32;
    localparam int DEPTH        = 64;
    localparam int CNT_MAX      = 7;
`ifdef RX_EARLY_READY_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pkt_done = 1'b0;
    logic             pkt_err = 1'b0;
    logic             flush = 1'b0;
    logic [OCC_W-1:0] occ = '0;
    logic             rx_data_ready;
    logic             rx_error;
    logic [CNT_W-1:0] pkt_count;
    logic             almost_full;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Model: mode 0 = idle, 1 = data ready, 2 = error
    int m_mode = 0;
    int m_cnt  = 0;
    int m_af   = 0;

    rx_data_ready_ctrl #(
        .OCC_W        (OCC_W),
        .CNT_W        (CNT_W),
        .AF_MARGIN    (AF_MARGIN),
        .EARLY_THRESH (EARLY_THRESH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_done         (pkt_done),
        .pkt_err          (pkt_err),
        .flush            (flush),
        .buffer_occupancy (occ),
        .rx_data_ready    (rx_data_ready),
        .rx_error         (rx_error),
        .pkt_count        (pkt_count),
        .almost_full      (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: what the host should see after each clock edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_cnt  <= 0;
            m_af   <= 0;
        end else begin
            m_af <= (int'(occ) >= DEPTH - AF_MARGIN) ? 1 : 0;
            if (m_mode == 2) begin
                if (flush) m_mode <= 0;
            end else if (flush) begin
                m_mode <= 0;
                m_cnt  <= 0;
            end else if (pkt_err) begin
                m_mode <= 2;
                m_cnt  <= 0;
            end else if (pkt_done) begin
                m_mode <= 1;
                m_cnt  <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end else if (m_mode == 1 && int'(occ) == 0) begin
                m_mode <= 0;
                m_cnt  <= 0;
            end else if (m_mode == 0 && EARLY == 1 && int'(occ) >= EARLY_THRESH) begin
                m_mode <= 1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_ready", int'(rx_data_ready), (m_mode == 1) ? 1 : 0);
            chk("model_error", int'(rx_error), (m_mode == 2) ? 1 : 0);
            chk("model_count", int'(pkt_count), m_cnt);
            chk("model_af", int'(almost_full), m_af);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", int'(rx_data_ready), 0);
        chk("rst_error", int'(rx_error), 0);
        chk("rst_count", int'(pkt_count), 0);
        chk("rst_af", int'(almost_full), 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Single packet, then drain
        occ = 7'd8;
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        chk("pkt1_ready", int'(rx_data_ready), 1);
        chk("pkt1_count", int'(pkt_count), 1);
        occ = 7'd0;
        tick();
        chk("drain_ready", int'(rx_data_ready), 0);
        chk("drain_count", int'(pkt_count), 0);

        // Nine packets: count saturates at 7
        occ = 7'd20;
        for (int i = 0; i < 9; i++) begin
            pkt_done = 1'b1;
            tick();
            chk("sat_count", int'(pkt_count), (i + 1 < 7) ? i + 1 : 7);
            chk("sat_ready", int'(rx_data_ready), 1);
        end
        pkt_done = 1'b0;

        // Error beats done, error is sticky, flush clears it
        pkt_err = 1'b1;
        pkt_done = 1'b1;
        tick();
        pkt_err = 1'b0;
        chk("err_error", int'(rx_error), 1);
        chk("err_ready", int'(rx_data_ready), 0);
        chk("err_count", int'(pkt_count), 0);
        tick();
        pkt_done = 1'b0;
        chk("err_ignore_done", int'(rx_error), 1);
        chk("err_ignore_count", int'(pkt_count), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_error", int'(rx_error), 0);
        chk("flush_ready", int'(rx_data_ready), 0);

        // Occupancy ramp up and down across the almost-full boundary
        for (int v = 0; v <= 64; v++) begin
            occ = 7'(v);
            tick();
            chk("af_up", int'(almost_full), (v >= 60) ? 1 : 0);
        end
        for (int v = 64; v >= 0; v--) begin
            occ = 7'(v);
            tick();
            chk("af_down", int'(almost_full), (v >= 60) ? 1 : 0);
        end

        // Asynchronous reset in READY with three packets counted
        occ = 7'd62;
        for (int i = 0; i < 3; i++) begin
            pkt_done = 1'b1;
            tick();
        end
        pkt_done = 1'b0;
        chk("pre_rst_count", int'(pkt_count), 3);
        chk("pre_rst_af", int'(almost_full), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_ready", int'(rx_data_ready), 0);
        chk("async_count", int'(pkt_count), 0);
        chk("async_af", int'(almost_full), 0);
        chk("async_error", int'(rx_error), 0);
        occ = 7'd0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("post_rst_ready", int'(rx_data_ready), 0);
        chk("post_rst_count", int'(pkt_count), 0);

        // Occupancy reaching the early threshold without pkt_done
        occ = 7'd31;
        tick();
        occ = 7'd32;
        tick();
        tick();
        chk("early_ready", int'(rx_data_ready), EARLY);
        chk("early_count", int'(pkt_count), 0);
        occ = 7'd0;
        tick();
        tick();

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 800; i++) begin
            pkt_done = ($urandom_range(0, 3) == 0);
            pkt_err  = ($urandom_range(0, 19) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 2) occ = 7'd0;
            else if (r < 4) occ = 7'($urandom_range(56, 127));
            else occ = 7'($urandom_range(1, 70));
            tick();
        end
        pkt_done = 1'b0;
        pkt_err  = 1'b0;
        flush    = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_data_ready_ctrl.md
Name: rx_data_ready_ctrl

Overview:
Parametrised receive-side data-ready controller for the CDL receiver. Tracks completed packets sitting in the RX FIFO and drives rx_data_ready to the host side until the FIFO drains. Adds what a single ready flag cannot provide: a packet count, an almost-full flag, error/flush handling and a configurable occupancy width. Sits between the RX control FSM (pkt_done/pkt_err) and the RX FIFO (buffer_occupancy).

Parameters:
OCC_W, 7, width of buffer_occupancy; FIFO depth is 2**(OCC_W-1) entries (64 at default).
CNT_W, 3, width of pkt_count; the count saturates at 2**CNT_W-1.
AF_MARGIN, 4, almost_full asserts when occupancy >= DEPTH-AF_MARGIN.
EARLY_THRESH, 32, occupancy level that raises early ready (optional feature only).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
pkt_done  in  1  one-cycle pulse: a packet was fully written into the FIFO
pkt_err  in  1  one-cycle pulse: the current packet was aborted with an error
flush  in  1  one-cycle pulse: host requests FIFO/state clear
buffer_occupancy  in  OCC_W  current RX FIFO entry count
rx_data_ready  out  1  data available for the host
rx_error  out  1  sticky error indication
pkt_count  out  CNT_W  completed packets since the FIFO was last empty
almost_full  out  1  FIFO near capacity

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE, rx_data_ready=0, rx_error=0, pkt_count=0, almost_full=0.
- The FSM has three states: IDLE, READY and ERROR. All outputs are registered or decoded from registers (Moore). Every response appears on the cycle after its trigger edge.
- IDLE:
  - pkt_err goes to ERROR.
  - Otherwise, pkt_done goes to READY.
- READY:
  - pkt_err goes to ERROR.
  - buffer_occupancy==0 with pkt_done=0 goes to IDLE.
  - Otherwise the FSM stays in READY.
- ERROR:
  - flush goes to IDLE.
  - pkt_done and pkt_err are ignored.
- flush in IDLE or READY goes to IDLE and clears pkt_count. Flush has priority over pkt_err, and pkt_err has priority over pkt_done.
- Output decode:
  - rx_data_ready = (state==READY).
  - rx_error = (state==ERROR).
- pkt_count:
  - Increments on pkt_done in IDLE or READY, unless an error or flush occurs in the same cycle.
  - Saturates at 2**CNT_W-1 (no wrap).
  - Clears on the READY->IDLE transition, on entry to ERROR, and on flush.
- pkt_done arriving while occupancy==0 in READY keeps the FSM in READY and increments the count.
- almost_full is a registered compare: buffer_occupancy >= (2**(OCC_W-1) - AF_MARGIN). It is evaluated in every state and cleared only by reset.
- Width rules:
  - Compares are unsigned at OCC_W bits.
  - Occupancy above 2**(OCC_W-1) is treated as full; no error is raised.
- Reset mid-packet abandons all state immediately. There are no pending pulses after rst deasserts.

Optional Feature:
Macro RX_EARLY_READY_EN.
- Defined: in IDLE, buffer_occupancy >= EARLY_THRESH (with no pkt_err and no flush) also transitions to READY. pkt_count is not incremented by this event. This lets the host start draining long packets before pkt_done.
- Undefined: only pkt_done enters READY. EARLY_THRESH is unused, and its compare logic must not be synthesised.

Decomposition:
- Package rx_pkg holds:
  - the state enum type rx_rdy_state_t (IDLE, READY, ERROR);
  - the default OCC_W and CNT_W localparams shared with the FIFO;
  - the function occ_depth(OCC_W) returning 2**(OCC_W-1).
- One sub-module, rx_sat_counter (parametrised CNT_W; inc, clr, count). It is reused by other CDL blocks needing saturating counters.
- The FSM and the almost_full compare stay in the top module.

Test Plan:
- Reset, then pkt_done with occupancy=8 → next cycle rx_data_ready=1, pkt_count=1. Occupancy drops to 0 → next cycle rx_data_ready=0, pkt_count=0.
- Nine pkt_done pulses with occupancy held at 20 (CNT_W=3) → pkt_count reaches 7 and holds at 7. rx_data_ready=1 throughout.
- In READY, pkt_err and pkt_done in the same cycle → ERROR: rx_error=1, rx_data_ready=0, pkt_count=0. Then flush → IDLE with rx_error=0 one cycle later.
- Occupancy ramps 0→64 (OCC_W=7, AF_MARGIN=4):
  - almost_full rises the cycle after occupancy=60.
  - almost_full falls the cycle after occupancy=59.
- rst asserted asynchronously mid-READY with pkt_count=3 → all outputs 0 immediately, without waiting for a clock edge. After release with no stimulus, outputs remain 0.
- With RX_EARLY_READY_EN and EARLY_THRESH=32: occupancy 31→32 in IDLE with no pkt_done → rx_data_ready=1 next cycle, pkt_count=0. Without the macro, rx_data_ready stays 0.
